asmd_requester: RTL
===================

Name: asmd_requester

Overview:
Initiator-side sequencer for the Start/F handshake of the ASMD counter controller/datapath pair. On a host `go` it launches a programmable number of back-to-back runs. Each run is one `start` pulse followed by waiting for flag F. At each F it captures the datapath result (A, E) and measures latency. It guards every run with a watchdog and reports completion or timeout to the host.

Parameters:
- TIMEOUT_CYCLES, 32, maximum WAIT_CLEAR+WAIT_F cycles per run before abort.
- RUN_CNT_W, 8, width of the run-count request and the completed-run counter.
- LAT_W, 6, width of the latency counter; must satisfy 2^LAT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  rising-edge clock.
- reset_b  in  1  asynchronous, active-low reset.
- go  in  1  host launch request, accepted only in IDLE.
- num_runs  in  RUN_CNT_W  runs to execute, sampled when go is accepted.
- start  out  1  registered; drives the controller Start input.
- A_in  in  4  datapath counter A.
- E_in  in  1  datapath flag E.
- F_in  in  1  datapath flag F (done).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of sequence, normal or timeout.
- timeout_err  out  1  sticky; cleared on next accepted go.
- run_count  out  RUN_CNT_W  runs completed in the current or last sequence.
- last_A  out  4  A_in captured at the most recent F.
- last_E  out  1  E_in captured at the most recent F.
- last_lat  out  LAT_W  latency of the most recent run.

Behaviour:
- Reset (async, any state including mid-run): state=IDLE; start, busy, done, timeout_err=0; run_count, last_A, last_E, last_lat=0.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_CLEAR, WAIT_F, GAP, DONE.
- IDLE:
  - go=1 and num_runs=0 -> DONE; no start is issued; run_count=0; timeout_err cleared.
  - go=1 and num_runs>0 -> LAUNCH; latch num_runs; run_count=0; timeout_err=0.
- LAUNCH: start=1 for exactly this one cycle; latency counter cleared; -> WAIT_CLEAR.
- WAIT_CLEAR: waits for F_in==0, i.e. the datapath acknowledged the clear. Then -> WAIT_F. Latency counter increments every cycle.
- WAIT_F: latency counter increments every cycle. On the first cycle with F_in==1, at that edge:
  - last_A<=A_in, last_E<=E_in, last_lat<=counter value including that cycle, run_count++.
  - If run_count+1 == latched num_runs -> DONE; else -> GAP.
- Timeout: if the counter reaches TIMEOUT_CYCLES in WAIT_CLEAR or WAIT_F with no capture:
  - timeout_err<=1; -> DONE.
  - run_count and the last_* registers are unchanged.
  - F_in==1 on the same cycle wins over timeout.
- GAP: one idle cycle with start=0, so the controller returns to idle; -> LAUNCH.
- DONE: done=1 for one cycle; busy=1; -> IDLE.
- go while busy is ignored and not queued.
- run_count saturates at 2^RUN_CNT_W-1; unreachable when num_runs is in range.
- Nominal run against the controller/datapath pair:
  - S_1 counts A from 0 to 12, S_2 sets F.
  - Result: F seen 15 cycles after the LAUNCH cycle; last_A=13, last_E=1, last_lat=15.
- Sequence cycle counts:
  - n runs: go-accept to done pulse = n*16 + (n-1) cycles of LAUNCH..capture/GAP, plus 1 for DONE.
  - Single run: done is asserted 17 cycles after go is sampled.

Decomposition:
- Shared package asmd_pkg:
  - state enum for the six states;
  - A_W=4;
  - the nominal expected constants (A_FINAL=13, LAT_NOMINAL=15) used by the bench.
- One sub-module, asmd_watchdog: latency/timeout counter with clear and enable inputs, count output and expired flag (count==TIMEOUT_CYCLES).
- The FSM and capture registers stay in asmd_requester.

Test Plan:
- Single run with the real controller/datapath: go, num_runs=1 -> one start pulse; done 17 cycles after go; run_count=1, last_A=13, last_E=1, last_lat=15, timeout_err=0.
- Three runs: num_runs=3 -> exactly 3 start pulses, each 17 cycles apart; run_count=3; single done pulse; last_lat=15.
- Zero runs: num_runs=0 -> no start; done 1 cycle after go; run_count=0; busy high for that one cycle only.
- Timeout: F_in tied 0, TIMEOUT_CYCLES=32 -> done and timeout_err=1 after 32 wait cycles; run_count=0; a new go clears timeout_err.
- go while busy: extra go pulses during a run -> ignored; start pulse count is unchanged.
- Reset mid-run: assert reset_b=0 in WAIT_F -> all outputs return to reset values immediately; after release, a fresh go completes normally with last_A=13.

Source files
------------

// File: rtl/asmd_pkg.sv
// Shared types and constants for the ASMD Start/F requester.
// Nominal result constants describe one run of the counter pair.
package asmd_pkg;

  localparam int A_W         = 4;
  localparam int A_FINAL     = 13;
  localparam int LAT_NOMINAL = 15;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CLEAR,
    WAIT_F,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/asmd_watchdog.sv
// Per-run latency/timeout counter for the requester.
// count includes the current wait cycle while enabled.
module asmd_watchdog
  import asmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int LAT_W          = 6
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             clear,
  input  logic             enable,
  output logic [LAT_W-1:0] count,
  output logic             expired
);

  logic [LAT_W-1:0] elapsed;

  assign count   = elapsed + LAT_W'(enable);
  assign expired = (count == LAT_W'(TIMEOUT_CYCLES));

  // Cycles already spent waiting; frozen once the limit is hit.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      elapsed <= '0;
    end else if (clear) begin
      elapsed <= '0;
    end else if (enable && !expired) begin
      elapsed <= count;
    end
  end

endmodule

// File: rtl/asmd_requester.sv
// Initiator for the ASMD Start/F handshake: runs n back-to-back
// start/F transactions, captures A/E and latency, guards each run.
module asmd_requester
  import asmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int RUN_CNT_W      = 8,
  parameter int LAT_W          = 6
) (
  input  logic                 clock,
  input  logic                 reset_b,
  input  logic                 go,
  input  logic [RUN_CNT_W-1:0] num_runs,
  output logic                 start,
  input  logic [A_W-1:0]       A_in,
  input  logic                 E_in,
  input  logic                 F_in,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [RUN_CNT_W-1:0] run_count,
  output logic [A_W-1:0]       last_A,
  output logic                 last_E,
  output logic [LAT_W-1:0]     last_lat
);

  state_t               state;
  logic [RUN_CNT_W-1:0] runs_req;
  logic [RUN_CNT_W-1:0] run_inc;
  logic                 wd_clear;
  logic                 wd_en;
  logic [LAT_W-1:0]     wd_count;
  logic                 wd_expired;

  assign run_inc  = run_count + {{(RUN_CNT_W-1){1'b0}}, 1'b1};
  assign wd_clear = (state == LAUNCH);
  assign wd_en    = (state == WAIT_CLEAR) || (state == WAIT_F);

  asmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .LAT_W         (LAT_W)
  ) u_wd (
    .clock  (clock),
    .reset_b(reset_b),
    .clear  (wd_clear),
    .enable (wd_en),
    .count  (wd_count),
    .expired(wd_expired)
  );

  // Sequencer FSM with registered handshake, status and capture outputs.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      runs_req    <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      run_count   <= '0;
      last_A      <= '0;
      last_E      <= 1'b0;
      last_lat    <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            runs_req    <= num_runs;
            run_count   <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (num_runs == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LAUNCH;
              start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT_CLEAR;
        end
        WAIT_CLEAR: begin
          if (wd_expired) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else if (!F_in) begin
            state <= WAIT_F;
          end
        end
        WAIT_F: begin
          if (F_in) begin
            last_A   <= A_in;
            last_E   <= E_in;
            last_lat <= wd_count;
            if (!(&run_count)) begin
              run_count <= run_inc;
            end
            if (run_inc == runs_req) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        GAP: begin
          state <= LAUNCH;
          start <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
